// File: rtl/fir_mac_engine_pkg.sv
// Shared types and helpers for the FIR multiply-accumulate engine and its lanes.
package fir_mac_engine_pkg;

   localparam int S_WIDTH_DEF = 24;
   localparam int S_DEPTH_DEF = 29;
   localparam int C_WIDTH_DEF = 18;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      SETTLE,
      MAC,
      ROUND,
      OUT
   } state_t;

   // Ceiling log2, never below 1 so it can size a counter directly.
   function automatic int fir_clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/fir_mac_engine_lane.sv
// One filter lane: tap/coefficient select, signed multiply, accumulate,
// then round-half-up and saturate back to sample width.
module fir_mac_lane
   import fir_mac_engine_pkg::*;
#(
   parameter int S_WIDTH = S_WIDTH_DEF,
   parameter int S_DEPTH = S_DEPTH_DEF,
   parameter int C_WIDTH = C_WIDTH_DEF,
   parameter int TW      = fir_clog2(S_DEPTH_DEF)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear_acc,
   input  logic                       mac_en,
   input  logic                       round_en,
   input  logic [TW-1:0]              tap_sel,
   input  logic [S_WIDTH*S_DEPTH-1:0] window,
   input  logic [C_WIDTH*S_DEPTH-1:0] coeffs,
   output logic [S_WIDTH-1:0]         result
);

   localparam int PW = S_WIDTH + C_WIDTH;
   localparam int AW = PW + fir_clog2(S_DEPTH);
   localparam logic signed [AW-1:0] ROUND_BIAS = {{(AW-1){1'b0}}, 1'b1} << (C_WIDTH - 2);

   logic signed [S_WIDTH-1:0] taps  [S_DEPTH];
   logic signed [C_WIDTH-1:0] coefs [S_DEPTH];

   for (genvar k = 0; k < S_DEPTH; k++) begin : g_unpack
      assign taps[k]  = window[k*S_WIDTH +: S_WIDTH];
      assign coefs[k] = coeffs[k*C_WIDTH +: C_WIDTH];
   end

   logic signed [S_WIDTH-1:0] tap_cur;
   logic signed [C_WIDTH-1:0] coef_cur;
   logic signed [PW-1:0]      product;
   logic signed [AW-1:0]      acc_q, acc_d;
   logic signed [AW-1:0]      rounded;
   logic [S_WIDTH-1:0]        result_q, result_d;

   // Everything above the sample's sign bit must agree, otherwise clamp to full scale.
   always_comb begin
      tap_cur  = taps[tap_sel];
      coef_cur = coefs[tap_sel];
      product  = PW'(tap_cur) * PW'(coef_cur);
      acc_d    = acc_q;
      if (clear_acc) begin
         acc_d = '0;
      end else if (mac_en) begin
         acc_d = acc_q + AW'(product);
      end
      rounded  = (acc_q + ROUND_BIAS) >>> (C_WIDTH - 1);
      result_d = result_q;
      if (round_en) begin
         if ((&rounded[AW-1:S_WIDTH-1]) || (~|rounded[AW-1:S_WIDTH-1])) begin
            result_d = rounded[S_WIDTH-1:0];
         end else if (rounded[AW-1]) begin
            result_d = {1'b1, {(S_WIDTH-1){1'b0}}};
         end else begin
            result_d = {1'b0, {(S_WIDTH-1){1'b1}}};
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: rtl/fir_mac_engine.sv
// Complex-input FIR engine: sequences one tap per cycle through the I and Q
// lanes, requests the next sample with canShift and hands results out on valid/ready.
module fir_mac_engine
   import fir_mac_engine_pkg::*;
#(
   parameter int S_WIDTH = S_WIDTH_DEF,
   parameter int S_DEPTH = S_DEPTH_DEF,
   parameter int C_WIDTH = C_WIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [S_WIDTH*S_DEPTH-1:0] shiftRegI,
   input  logic [S_WIDTH*S_DEPTH-1:0] shiftRegQ,
   input  logic                       empty,
   input  logic [C_WIDTH*S_DEPTH-1:0] coeffs,
   output logic                       canShift,
   output logic [S_WIDTH-1:0]         outI,
   output logic [S_WIDTH-1:0]         outQ,
   output logic                       outValid,
   input  logic                       outReady
);

   localparam int TW = fir_clog2(S_DEPTH);
   localparam logic [TW-1:0] LAST_TAP = TW'(S_DEPTH - 1);

   state_t        state_q, state_d;
   logic [TW-1:0] tap_q, tap_d;
   logic          can_shift_q, can_shift_d;
   logic          out_valid_q, out_valid_d;
   logic          clear_acc, mac_en, round_en;

   // SETTLE gives the fetch stage one cycle to present the shifted window before MAC reads it.
   always_comb begin
      state_d     = state_q;
      tap_d       = tap_q;
      can_shift_d = 1'b0;
      out_valid_d = out_valid_q;
      clear_acc   = 1'b0;
      mac_en      = 1'b0;
      round_en    = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               state_d     = SHIFT;
               can_shift_d = 1'b1;
            end
         end
         SHIFT: state_d = SETTLE;
         SETTLE: begin
            clear_acc = 1'b1;
            tap_d     = '0;
            state_d   = MAC;
         end
         MAC: begin
            mac_en = 1'b1;
            if (tap_q == LAST_TAP) begin
               state_d = ROUND;
            end else begin
               tap_d = tap_q + TW'(1);
            end
         end
         ROUND: begin
            round_en    = 1'b1;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (outReady) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         tap_q       <= '0;
         can_shift_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tap_q       <= tap_d;
         can_shift_q <= can_shift_d;
         out_valid_q <= out_valid_d;
      end
   end

   fir_mac_lane #(
      .S_WIDTH (S_WIDTH),
      .S_DEPTH (S_DEPTH),
      .C_WIDTH (C_WIDTH),
      .TW      (TW)
   ) u_lane_i (
      .clk       (clk),
      .reset     (reset),
      .clear_acc (clear_acc),
      .mac_en    (mac_en),
      .round_en  (round_en),
      .tap_sel   (tap_q),
      .window    (shiftRegI),
      .coeffs    (coeffs),
      .result    (outI)
   );

   fir_mac_lane #(
      .S_WIDTH (S_WIDTH),
      .S_DEPTH (S_DEPTH),
      .C_WIDTH (C_WIDTH),
      .TW      (TW)
   ) u_lane_q (
      .clk       (clk),
      .reset     (reset),
      .clear_acc (clear_acc),
      .mac_en    (mac_en),
      .round_en  (round_en),
      .tap_sel   (tap_q),
      .window    (shiftRegQ),
      .coeffs    (coeffs),
      .result    (outQ)
   );

   assign canShift = can_shift_q;
   assign outValid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: a fetch-stage stand-in supplies windows,
// an arithmetic model predicts each frame's outputs and a scoreboard compares them.
module tb_fir_mac_engine;

   localparam int S_WIDTH      = 24;
   localparam int S_DEPTH      = 29;
   localparam int C_WIDTH      = 18;
   localparam int WW           = S_WIDTH * S_DEPTH;
   localparam int CW           = C_WIDTH * S_DEPTH;
   localparam int FRAME_CYCLES = S_DEPTH + 5;

   logic                clk = 1'b0;
   logic                reset;
   logic [WW-1:0]       shift_reg_i, shift_reg_q;
   logic                empty;
   logic [CW-1:0]       coeffs;
   logic                can_shift;
   logic [S_WIDTH-1:0]  out_i, out_q;
   logic                out_valid;
   logic                out_ready;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int n_shift     = 0;
   int n_hs        = 0;
   int last_shift  = -1;
   bit spacing_on  = 1'b0;
   bit pend_valid  = 1'b0;
   logic [WW-1:0] pend_i, pend_q;
   logic [2*S_WIDTH-1:0] exp_q[$];

   fir_mac_engine #(
      .S_WIDTH (S_WIDTH),
      .S_DEPTH (S_DEPTH),
      .C_WIDTH (C_WIDTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .shiftRegI (shift_reg_i),
      .shiftRegQ (shift_reg_q),
      .empty     (empty),
      .coeffs    (coeffs),
      .canShift  (can_shift),
      .outI      (out_i),
      .outQ      (out_q),
      .outValid  (out_valid),
      .outReady  (out_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Plain integer FIR: dot product, add half an LSB, arithmetic shift, clamp.
   function automatic logic [S_WIDTH-1:0] modelLane(input logic [WW-1:0] win, input logic [CW-1:0] cf);
      longint acc, r, hi, lo;
      acc = 0;
      for (int k = 0; k < S_DEPTH; k++) begin
         acc += longint'($signed(win[k*S_WIDTH +: S_WIDTH])) * longint'($signed(cf[k*C_WIDTH +: C_WIDTH]));
      end
      r  = (acc + (longint'(1) <<< (C_WIDTH - 2))) >>> (C_WIDTH - 1);
      hi = (longint'(1) <<< (S_WIDTH - 1)) - 1;
      lo = -(longint'(1) <<< (S_WIDTH - 1));
      if (r > hi) r = hi;
      else if (r < lo) r = lo;
      return r[S_WIDTH-1:0];
   endfunction

   function automatic logic [WW-1:0] randWindow();
      logic [WW-1:0] w;
      for (int k = 0; k < S_DEPTH; k++) begin
         w[k*S_WIDTH +: S_WIDTH] = S_WIDTH'($urandom);
      end
      return w;
   endfunction

   function automatic logic [CW-1:0] randCoeffs();
      logic [CW-1:0] c;
      for (int k = 0; k < S_DEPTH; k++) begin
         c[k*C_WIDTH +: C_WIDTH] = C_WIDTH'($urandom);
      end
      return c;
   endfunction

   task automatic applyStimulus(input logic [WW-1:0] win_i, input logic [WW-1:0] win_q);
      pend_i     = win_i;
      pend_q     = win_q;
      pend_valid = 1'b1;
   endtask

   // Fetch-stage stand-in: each canShift presents a new window and books its expected result.
   always @(negedge clk) begin
      if (can_shift) begin
         n_shift++;
         if (spacing_on && last_shift >= 0) begin
            checkOutput("shift_spacing", 64'(cyc - last_shift), 64'(FRAME_CYCLES));
         end
         last_shift = cyc;
         if (pend_valid) begin
            shift_reg_i = pend_i;
            shift_reg_q = pend_q;
            pend_valid  = 1'b0;
         end else begin
            shift_reg_i = randWindow();
            shift_reg_q = randWindow();
         end
         exp_q.push_back({modelLane(shift_reg_i, coeffs), modelLane(shift_reg_q, coeffs)});
      end
   end

   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_result: got outValid=1 with outI=%0h, expected no pending frame", out_i);
         end else begin
            checkOutput("outI", 64'(out_i), 64'(exp_q[0][2*S_WIDTH-1:S_WIDTH]));
            checkOutput("outQ", 64'(out_q), 64'(exp_q[0][S_WIDTH-1:0]));
         end
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (!reset && out_valid && out_ready) begin
         n_hs++;
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
   end

   task automatic runFrame(output logic [S_WIDTH-1:0] res_i, output logic [S_WIDTH-1:0] res_q);
      int shift_lat, valid_lat;
      repeat (2) @(negedge clk);
      empty     = 1'b0;
      shift_lat = 0;
      do begin
         @(negedge clk);
         shift_lat++;
      end while (!can_shift && shift_lat < 20);
      empty = 1'b1;
      checkOutput("empty_to_canShift", 64'(shift_lat), 64'd1);
      valid_lat = 0;
      do begin
         @(negedge clk);
         valid_lat++;
      end while (!out_valid && valid_lat < 100);
      checkOutput("canShift_to_outValid", 64'(valid_lat), 64'(S_DEPTH + 3));
      res_i = out_i;
      res_q = out_q;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WW-1:0]      w_i, w_q;
      logic [S_WIDTH-1:0] res_i, res_q, held_i, held_q;
      int base_s, base_h, t;

      reset       = 1'b1;
      empty       = 1'b1;
      out_ready   = 1'b1;
      shift_reg_i = '0;
      shift_reg_q = '0;
      coeffs      = '0;
      coeffs[C_WIDTH-1:0] = 18'h1FFFF;
      repeat (3) @(negedge clk);
      checkOutput("reset_canShift", 64'(can_shift), 64'd0);
      checkOutput("reset_outValid", 64'(out_valid), 64'd0);
      checkOutput("reset_outI", 64'(out_i), 64'd0);
      checkOutput("reset_outQ", 64'(out_q), 64'd0);
      reset = 1'b0;

      $display("[TB] flow control: empty held high");
      base_s = n_shift;
      repeat (50) @(negedge clk);
      checkOutput("idle_no_canShift", 64'(n_shift - base_s), 64'd0);

      $display("[TB] impulse frame");
      w_i = '0;
      w_q = '0;
      w_i[S_WIDTH-1:0] = 24'h400000;
      w_q[S_WIDTH-1:0] = 24'hC00000;
      applyStimulus(w_i, w_q);
      runFrame(res_i, res_q);
      checkOutput("impulse_outI", 64'(res_i), 64'h3FFFE0);
      checkOutput("impulse_outQ", 64'(res_q), 64'hC00020);

      $display("[TB] saturation frames");
      for (int k = 0; k < S_DEPTH; k++) begin
         coeffs[k*C_WIDTH +: C_WIDTH] = 18'h1FFFF;
         w_i[k*S_WIDTH +: S_WIDTH]    = 24'h7FFFFF;
         w_q[k*S_WIDTH +: S_WIDTH]    = 24'h800000;
      end
      applyStimulus(w_i, w_q);
      runFrame(res_i, res_q);
      checkOutput("sat_pos_outI", 64'(res_i), 64'h7FFFFF);
      checkOutput("sat_neg_outQ", 64'(res_q), 64'h800000);
      applyStimulus(w_q, w_i);
      runFrame(res_i, res_q);
      checkOutput("sat_neg_outI", 64'(res_i), 64'h800000);
      checkOutput("sat_pos_outQ", 64'(res_q), 64'h7FFFFF);

      $display("[TB] backpressure");
      repeat (2) @(negedge clk);
      coeffs    = randCoeffs();
      out_ready = 1'b0;
      runFrame(res_i, res_q);
      empty  = 1'b0;
      base_s = n_shift;
      held_i = out_i;
      held_q = out_q;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("bp_outValid", 64'(out_valid), 64'd1);
         checkOutput("bp_outI_stable", 64'(out_i), 64'(held_i));
         checkOutput("bp_outQ_stable", 64'(out_q), 64'(held_q));
      end
      checkOutput("bp_no_canShift", 64'(n_shift - base_s), 64'd0);
      empty     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_outValid", 64'(out_valid), 64'd0);

      $display("[TB] reset during MAC");
      repeat (2) @(negedge clk);
      coeffs = randCoeffs();
      empty  = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!can_shift && t < 20);
      checkOutput("rst_frame_started", 64'(can_shift), 64'd1);
      repeat (11) @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      pend_valid = 1'b0;
      #1;
      checkOutput("rst_mid_outValid", 64'(out_valid), 64'd0);
      checkOutput("rst_mid_outI", 64'(out_i), 64'd0);
      checkOutput("rst_mid_outQ", 64'(out_q), 64'd0);
      checkOutput("rst_mid_canShift", 64'(can_shift), 64'd0);
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      base_s = n_shift;
      base_h = n_hs;
      t = 0;
      while (n_hs - base_h < 3 && t < 4 * FRAME_CYCLES) begin
         @(negedge clk);
         t++;
      end
      empty = 1'b1;
      checkOutput("rst_frames_done", 64'(n_hs - base_h), 64'd3);
      repeat (40) @(negedge clk);
      checkOutput("rst_one_shift_per_frame", 64'(n_shift - base_s), 64'd3);

      $display("[TB] streaming random frames");
      for (int blk = 0; blk < 5; blk++) begin
         coeffs     = randCoeffs();
         last_shift = -1;
         spacing_on = 1'b1;
         base_h     = n_hs;
         empty      = 1'b0;
         t = 0;
         while (n_hs - base_h < 20 && t < 21 * FRAME_CYCLES) begin
            @(negedge clk);
            t++;
         end
         empty      = 1'b1;
         spacing_on = 1'b0;
         checkOutput("stream_frames", 64'(n_hs - base_h), 64'd20);
         repeat (5) @(negedge clk);
      end

      checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
